dice_traffic_seq: RTL and testbench

Parametrised successor to the fixed dice/traffic-light multiplexer. It contains two engines behind a mode select:
- An N-faced dice counter with a roll-complete strobe.
- A traffic-light sequencer with per-phase programmable dwell times and a pedestrian-request early exit from GREEN.

It drives the board display/LED output directly from the selected engine.

---
 rtl/dice_traffic_seq.sv | 150 +++++++++++++++
 tb/tb_dice_traffic_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dice_traffic_seq.sv
// rtl/dice_traffic_seq.sv - dice counter and traffic-light sequencer behind a mode select
//
// Two engines share one display output. Only the engine picked by sel
// advances; the other freezes all of its state so it resumes exactly
// where it stopped when selected again.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset (both engines)
//   sel        in   1 = traffic engine, 0 = dice engine
//   button     in   dice advance request, sampled every cycle
//   ped_req    in   pedestrian request, latched until next RED entry
//   result     out  [RES_W] value of the selected engine (combinational mux)
//   roll_valid out  one-cycle pulse after the button falls in dice mode
module dice_traffic_seq #(
    parameter int DICE_FACES       = 6,
    parameter int RES_W            = 4,
    parameter int CNT_W            = 8,
    parameter int RED_CYCLES       = 4,
    parameter int RA_CYCLES        = 1,
    parameter int GREEN_CYCLES     = 6,
    parameter int GREEN_MIN_CYCLES = 2,
    parameter int AMBER_CYCLES     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             button,
    input  logic             ped_req,
    output logic [RES_W-1:0] result,
    output logic             roll_valid
);

    // Light encodings are {R,A,G}.
    localparam logic [2:0] ST_RED       = 3'b100;
    localparam logic [2:0] ST_RED_AMBER = 3'b110;
    localparam logic [2:0] ST_GREEN     = 3'b001;
    localparam logic [2:0] ST_AMBER     = 3'b010;

    // A phase advances on the edge where dwell reaches its last value.
    localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] RA_LAST    = CNT_W'(RA_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GMIN_LAST  = CNT_W'(GREEN_MIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] AMBER_LAST = CNT_W'(AMBER_CYCLES - 1);

    localparam logic [RES_W-1:0] FACES_V = RES_W'(DICE_FACES);
    localparam logic [RES_W-1:0] ONE_V   = RES_W'(1);

    logic [RES_W-1:0] dice_q, dice_d;
    logic             btn_q, btn_d;
    logic             rv_q, rv_d;

    logic [2:0]       tl_q, tl_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             ped_q, ped_d;

    logic             tl_adv;
    logic [2:0]       tl_nxt;

    // Dice engine
    always_comb begin
        dice_d = dice_q;
        btn_d  = btn_q;
        rv_d   = 1'b0;
        if (!sel) begin
            btn_d = button;
            rv_d  = btn_q & ~button;
            // Out-of-range values self-start to 1 whatever the button does.
            if (dice_q == '0 || dice_q > FACES_V) begin
                dice_d = ONE_V;
            end else if (button) begin
                dice_d = (dice_q == FACES_V) ? ONE_V : dice_q + ONE_V;
            end
        end
    end

    // Traffic engine
    always_comb begin
        tl_adv = 1'b0;
        tl_nxt = ST_RED;
        case (tl_q)
            ST_RED: begin
                tl_adv = (dwell_q == RED_LAST);
                tl_nxt = ST_RED_AMBER;
            end
            ST_RED_AMBER: begin
                tl_adv = (dwell_q == RA_LAST);
                tl_nxt = ST_GREEN;
            end
            ST_GREEN: begin
                // A pending pedestrian request cuts GREEN short once the
                // minimum dwell has been served.
                tl_adv = (dwell_q == GREEN_LAST) || (ped_q && dwell_q >= GMIN_LAST);
                tl_nxt = ST_AMBER;
            end
            ST_AMBER: begin
                tl_adv = (dwell_q == AMBER_LAST);
                tl_nxt = ST_RED;
            end
            default: begin
                tl_adv = 1'b1;
                tl_nxt = ST_RED;
            end
        endcase
    end

    always_comb begin
        tl_d    = tl_q;
        dwell_d = dwell_q;
        ped_d   = ped_q;
        if (sel) begin
            if (tl_adv) begin
                tl_d    = tl_nxt;
                dwell_d = '0;
            end else begin
                dwell_d = dwell_q + CNT_W'(1);
            end
            // Clear on RED entry wins over a simultaneous request.
            if (tl_adv && tl_nxt == ST_RED) begin
                ped_d = 1'b0;
            end else if (ped_req) begin
                ped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dice_q  <= '0;
            btn_q   <= 1'b0;
            rv_q    <= 1'b0;
            tl_q    <= ST_RED;
            dwell_q <= '0;
            ped_q   <= 1'b0;
        end else begin
            dice_q  <= dice_d;
            btn_q   <= btn_d;
            rv_q    <= rv_d;
            tl_q    <= tl_d;
            dwell_q <= dwell_d;
            ped_q   <= ped_d;
        end
    end

    assign result     = sel ? RES_W'(tl_q) : dice_q;
    // Gated so a pulse registered on the last dice edge never shows in traffic mode.
    assign roll_valid = rv_q & ~sel;

endmodule

// File: tb/tb_dice_traffic_seq.sv
// tb/tb_dice_traffic_seq.sv - scoreboard bench for dice_traffic_seq
module tb_dice_traffic_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b1;
    logic       button = 1'b0;
    logic       ped_req = 1'b0;
    logic [3:0] result;
    logic       roll_valid;

    int total = 0;
    int bad   = 0;
    int step  = 0;
    logic [3:0] exp_res_q[$];
    logic       exp_rv_q[$];

    localparam logic [3:0] R  = 4'b0100;
    localparam logic [3:0] RA = 4'b0110;
    localparam logic [3:0] G  = 4'b0001;
    localparam logic [3:0] A  = 4'b0010;

    dice_traffic_seq dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .button     (button),
        .ped_req    (ped_req),
        .result     (result),
        .roll_valid (roll_valid)
    );

    always #5 clk = ~clk;

    // Drive inputs for n cycles and queue the outputs expected during each cycle.
    task automatic run(input int n, input logic r, input logic s, input logic b,
                       input logic p, input logic [3:0] er, input logic ev);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst     = r;
            sel     = s;
            button  = b;
            ped_req = p;
            exp_res_q.push_back(er);
            exp_rv_q.push_back(ev);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_res_q.size() > 0) begin
            logic [3:0] er;
            logic       ev;
            er = exp_res_q.pop_front();
            ev = exp_rv_q.pop_front();
            step++;
            total++;
            if (result !== er) begin
                bad++;
                $display("FAIL step%0d result: got %b want %b", step, result, er);
            end
            total++;
            if (roll_valid !== ev) begin
                bad++;
                $display("FAIL step%0d roll_valid: got %b want %b", step, roll_valid, ev);
            end
        end
    end

    initial begin
        // Reset in traffic mode, then one full cycle of phases.
        run(1, 1, 1, 0, 0, R, 0);
        run(4, 0, 1, 0, 0, R, 0);
        run(1, 0, 1, 0, 0, RA, 0);
        run(6, 0, 1, 0, 0, G, 0);
        run(2, 0, 1, 0, 0, A, 0);

        // Pedestrian pulse in first RED cycle: short GREEN, then a full one.
        run(1, 0, 1, 0, 1, R, 0);
        run(3, 0, 1, 0, 0, R, 0);
        run(1, 0, 1, 0, 0, RA, 0);
        run(2, 0, 1, 0, 0, G, 0);
        run(2, 0, 1, 0, 0, A, 0);
        run(4, 0, 1, 0, 0, R, 0);
        run(1, 0, 1, 0, 0, RA, 0);
        run(6, 0, 1, 0, 0, G, 0);
        run(2, 0, 1, 0, 0, A, 0);

        // Leave GREEN at dwell 3 for five dice cycles with the button toggling.
        run(4, 0, 1, 0, 0, R, 0);
        run(1, 0, 1, 0, 0, RA, 0);
        run(3, 0, 1, 0, 0, G, 0);
        run(1, 0, 0, 1, 0, 4'd0, 0);
        run(1, 0, 0, 0, 0, 4'd1, 0);
        run(1, 0, 0, 1, 0, 4'd1, 1);
        run(1, 0, 0, 0, 0, 4'd2, 0);
        run(1, 0, 0, 1, 0, 4'd2, 1);
        run(3, 0, 1, 1, 0, G, 0);
        run(2, 0, 1, 1, 0, A, 0);
        run(1, 0, 1, 1, 0, R, 0);
        // Back to dice: value held at 3, held button history yields a pulse.
        run(1, 0, 0, 0, 0, 4'd3, 0);
        run(1, 0, 0, 0, 0, 4'd3, 1);
        run(1, 0, 0, 1, 0, 4'd3, 0);
        run(1, 0, 0, 1, 0, 4'd4, 0);

        // Reset mid-roll in dice mode, then self-start with button low.
        run(1, 1, 0, 1, 0, 4'd5, 0);
        run(1, 1, 0, 1, 0, 4'd0, 0);
        run(1, 0, 0, 0, 0, 4'd0, 0);
        run(2, 0, 0, 0, 0, 4'd1, 0);

        // Fresh reset, button high 7 cycles: 1..6 then wrap to 1.
        run(1, 1, 0, 0, 0, 4'd1, 0);
        for (int i = 0; i < 7; i++) begin
            logic [3:0] v;
            v = 4'(i);
            run(1, 0, 0, 1, 0, v, 0);
        end
        run(1, 0, 0, 0, 0, 4'd1, 0);
        run(1, 0, 0, 0, 0, 4'd1, 1);
        run(2, 0, 0, 0, 0, 4'd1, 0);

        // Traffic after a dice-mode reset starts at RED with full dwell;
        // then reset in first AMBER cycle with a pedestrian request.
        run(4, 0, 1, 0, 0, R, 0);
        run(1, 0, 1, 0, 0, RA, 0);
        run(6, 0, 1, 0, 0, G, 0);
        run(1, 1, 1, 0, 1, A, 0);
        run(4, 0, 1, 0, 0, R, 0);
        run(1, 0, 1, 0, 0, RA, 0);
        run(6, 0, 1, 0, 0, G, 0);
        run(2, 0, 1, 0, 0, A, 0);
        run(1, 0, 1, 0, 0, R, 0);

        for (int i = 0; i < 10 && exp_res_q.size() > 0; i++) @(posedge clk);
        total++;
        if (exp_res_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_res_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
